coin_acceptor: RTL
==================

# coin_acceptor

Front-end coin acceptor that drives the vending-machine FSM's coin inputs. It synchronizes and debounces two raw coin-sensor lines and classifies each coin as nickel or dime. Accepted coins are buffered in a small FIFO and replayed to the vending machine as clean, single-cycle `Nickel`/`Dime` pulses, paced so that no two pulses are adjacent. While the machine asserts `Dispense`, no pulses are sent.

## Interface
Parameters:
- DEBOUNCE, 4, consecutive synchronized-high cycles required to accept a coin, and consecutive low cycles required to re-arm (range 2–15).
- FIFO_DEPTH, 4, coin buffer entries (power of two, 2–8).
- GAP, 1, idle cycles forced after every output pulse (range 1–7).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- NickelRaw  in  1  raw nickel sensor; asynchronous and may bounce.
- DimeRaw  in  1  raw dime sensor; asynchronous and may bounce.
- Dispense  in  1  from vending machine; while high, no pulse is launched.
- Nickel  out  1  one-cycle pulse; one nickel credited.
- Dime  out  1  one-cycle pulse; one dime credited.
- Reject  out  1  one-cycle pulse; coin returned (FIFO full or both sensors accepted in the same cycle).
- Count  out  4  current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Synchronizer:
  - Each raw input passes through 2 flops; the debouncers see only the second-flop outputs (`nS`, `dS`).
- Debouncer (one per sensor; 4-bit counter plus an `armed` flag):
  - While armed: the counter increments while the synchronized input is 1 and clears to 0 on any 0.
  - When the counter reaches DEBOUNCE, the sensor issues an accept strobe for one cycle, clears `armed`, and clears the counter.
  - While disarmed: the counter increments on 0 and clears on 1. On reaching DEBOUNCE, `armed` is set and the counter clears.
  - Result: a coin held high indefinitely yields exactly one accept, and bounces shorter than DEBOUNCE cycles yield none.
- Classification, evaluated on the accept strobes in the same cycle:
  - Nickel strobe only: push code 0.
  - Dime strobe only: push code 1.
  - Both strobes: push nothing; pulse `Reject`.
  - Push while Count == FIFO_DEPTH (pre-edge value): coin dropped; pulse `Reject`. This applies even if a pop occurs in the same cycle.
- FIFO:
  - Circular buffer, 1-bit entries. Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - Count has one extra bit.
  - Push and pop in the same cycle leave Count unchanged.
- Output FSM, states IDLE, PULSE, GAP:
  - IDLE → PULSE when Count > 0 and Dispense == 0. This pops the head entry and registers `Nickel` (code 0) or `Dime` (code 1) high for the PULSE cycle.
  - PULSE → GAP unconditionally, with a gap counter loaded to GAP.
  - GAP: the counter decrements each cycle; at 1 the FSM returns to IDLE.
  - Dispense is ignored in PULSE and GAP. A launched pulse always completes.
- Reset (any cycle, including mid-pulse or mid-debounce):
  - FSM returns to IDLE.
  - FIFO is emptied; pointers and Count go to 0.
  - Both debouncers go to armed with counter 0.
  - Synchronizer flops clear.
  - Buffered coins are discarded; no pulse is emitted for them.

## Timing
- Reset values: Nickel=0, Dime=0, Reject=0, Count=0, FSM=IDLE.
- Every output is registered; there are no combinational paths from inputs to outputs.
- A raw input rising before edge k and held steady:
  - Accept and push occur at edge k+1+DEBOUNCE; Count increments then.
  - `Reject` (when applicable) is high during the cycle after that same edge.
- Pop-to-pulse: with an empty FIFO, IDLE state, and Dispense low, the pulse is high for exactly the cycle after edge k+2+DEBOUNCE. Total raw-to-pulse latency is DEBOUNCE+2 edges.
- Pulse spacing: back-to-back buffered coins produce pulses every GAP+1 cycles.
- `Nickel` and `Dime` are never high together, and never high in adjacent cycles.
- Dispense rising on the same edge that IDLE would launch blocks the launch. The launch happens on the first edge sampling Dispense == 0.

## Test plan
- Clean nickels: three NickelRaw highs of 10 cycles each, separated by 10 low cycles, with Dispense=0.
  - Expect 3 `Nickel` pulses, each exactly 1 cycle wide.
  - First pulse is 6 edges after the raw rise.
  - No `Dime`, no `Reject`.
- Bounce rejection: DimeRaw toggles 1,0,1,1,0,1 (runs shorter than 4), then stays high for 8 cycles.
  - Expect exactly 1 `Dime` pulse.
- Hold-off and burst: Dispense=1 while 4 coins arrive (N, D, D, N); Count reaches 4. Release Dispense.
  - Expect pulses Nickel, Dime, Dime, Nickel, 2 cycles apart.
  - Count steps 4→3→2→1→0.
- Full FIFO: with Dispense=1, insert 5 nickels.
  - Expect 5th coin to give `Reject`=1 for 1 cycle, Count stays at 4.
  - After Dispense=0, exactly 4 `Nickel` pulses.
- Simultaneous sensors: NickelRaw and DimeRaw rise on the same edge and hold for 6 cycles.
  - Expect one `Reject`, Count=0, no output pulse.
- Reset mid-operation: Count=3, Reset asserted for 2 cycles during a PULSE cycle.
  - Expect all outputs 0 from the next edge, Count=0.
  - No further pulses until new coins arrive.
  - A new dime afterwards gives 1 `Dime` pulse with normal latency.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronized, debounced two-sensor coin front end
// that buffers coins and replays paced Nickel/Dime credit pulses.
module coin_acceptor #(
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       NickelRaw,
  input  logic       DimeRaw,
  input  logic       Dispense,
  output logic       Nickel,
  output logic       Dime,
  output logic       Reject,
  output logic [3:0] Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [2:0] GAP_LD = 3'(GAP);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  // bit 0 is the nickel sensor, bit 1 the dime sensor
  logic [1:0] s1, s2;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {DimeRaw, NickelRaw};
      s2 <= s1;
    end
  end

  logic [1:0][3:0] dcnt;
  logic [1:0]      armed;
  logic [1:0]      acc;

  always_comb begin
    for (int i = 0; i < 2; i++)
      acc[i] = armed[i] && s2[i] && (dcnt[i] == DB_LAST);
  end

  // disarmed sensors wait for a stable low run before the next coin
  always_ff @(posedge CLK) begin
    if (Reset) begin
      armed <= 2'b11;
      dcnt  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != armed[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          dcnt[i]  <= '0;
          armed[i] <= ~armed[i];
        end else begin
          dcnt[i] <= dcnt[i] + 4'd1;
        end
      end
    end
  end

  logic [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0]         wp, rp;
  logic [AW:0]           cnt;
  logic                  push, push_code, rej_n, pop;

  always_comb begin
    push      = 1'b0;
    push_code = 1'b0;
    rej_n     = 1'b0;
    case (acc)
      2'b01: push = 1'b1;
      2'b10: begin
        push      = 1'b1;
        push_code = 1'b1;
      end
      2'b11:   rej_n = 1'b1;
      default: ;
    endcase
    if (push && cnt == FULL) begin
      push  = 1'b0;
      rej_n = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      mem    <= '0;
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      Reject <= 1'b0;
    end else begin
      Reject <= rej_n;
      if (push) begin
        mem[wp] <= push_code;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign Count = 4'(cnt);

  state_t     st, st_n;
  logic [2:0] gcnt, gcnt_n;
  logic       nk_n, dm_n;
  logic       ready, launch;

  // the last gap cycle may launch directly so spacing is GAP+1
  assign ready  = (st == S_IDLE) ||
                  (st == S_GAP && gcnt == 3'd1);
  assign launch = ready && (cnt != '0) && !Dispense;

  always_comb begin
    st_n   = st;
    gcnt_n = gcnt;
    nk_n   = 1'b0;
    dm_n   = 1'b0;
    pop    = 1'b0;
    unique case (st)
      S_IDLE:  ;
      S_PULSE: begin
        st_n   = S_GAP;
        gcnt_n = GAP_LD;
      end
      S_GAP: begin
        if (gcnt == 3'd1) st_n = S_IDLE;
        else gcnt_n = gcnt - 3'd1;
      end
      default: st_n = S_IDLE;
    endcase
    if (launch) begin
      st_n = S_PULSE;
      pop  = 1'b1;
      nk_n = ~mem[rp];
      dm_n = mem[rp];
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      st     <= S_IDLE;
      gcnt   <= '0;
      Nickel <= 1'b0;
      Dime   <= 1'b0;
    end else begin
      st     <= st_n;
      gcnt   <= gcnt_n;
      Nickel <= nk_n;
      Dime   <= dm_n;
    end
  end

endmodule
